// File: rtl/demux2x5_stream.sv
// Buffered 1-to-2 stream demultiplexer: each word is steered by in_sel into one of
// two independent FIFO channels, each with its own handshake and transfer counter.
module demux2x5_stream #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_ready_vec;
    logic [WIDTH-1:0] head [2];
    logic [CNT_W-1:0] xfer [2];

    assign out_ready_vec = {out1_ready, out0_ready};

    // Readiness depends only on the selected channel's registered occupancy,
    // so a stalled channel never blocks words bound for the other one.
    assign in_ready = !full[in_sel];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [WIDTH-1:0] mem_reg [DEPTH];
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W:0]   count_reg;
            logic [CNT_W-1:0] xfer_reg;

            assign full[gi]  = (count_reg == (PTR_W + 1)'(DEPTH));
            assign empty[gi] = (count_reg == '0);
            assign push[gi]  = in_valid && !full[gi] && (in_sel == 1'(gi));
            assign pop[gi]   = !empty[gi] && out_ready_vec[gi];
            assign head[gi]  = mem_reg[rd_ptr_reg];
            assign xfer[gi]  = xfer_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                    xfer_reg   <= '0;
                end else begin
                    if (push[gi]) begin
                        mem_reg[wr_ptr_reg] <= in_data;
                        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
                        xfer_reg            <= xfer_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    // Simultaneous push and pop leaves the occupancy unchanged.
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out0_valid = !empty[0];
    assign out1_valid = !empty[1];
    assign cnt0       = xfer[0];
    assign cnt1       = xfer[1];

endmodule

// File: tb/tb_demux2x5_stream.sv
// Self-checking bench for demux2x5_stream: a vector table for routing/backpressure,
// hand-written multi-cycle sequences, and a per-cycle scoreboard of both channels.
module tb_demux2x5_stream;

    localparam int WIDTH = 5;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    demux2x5_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected words per channel and expected counters.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [CNT_W-1:0] m_cnt0 = '0;
    logic [CNT_W-1:0] m_cnt1 = '0;
    bit               mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic m_ready;
            logic m_v0;
            logic m_v1;
            m_v0    = (q0.size() != 0);
            m_v1    = (q1.size() != 0);
            m_ready = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
            check("sb_cnt0", 32'(cnt0), 32'(m_cnt0));
            check("sb_cnt1", 32'(cnt1), 32'(m_cnt1));
            check("sb_out0_valid", 32'(out0_valid), 32'(m_v0));
            check("sb_out1_valid", 32'(out1_valid), 32'(m_v1));
            check("sb_in_ready", 32'(in_ready), 32'(m_ready));
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                m_cnt0 = '0;
                m_cnt1 = '0;
            end else begin
                if (m_v0 && out0_ready) begin
                    logic [WIDTH-1:0] e0;
                    e0 = q0.pop_front();
                    check("sb_out0_data", 32'(out0_data), 32'(e0));
                    $display("pop  ch0 data=%02h exp=%02h", out0_data, e0);
                end
                if (m_v1 && out1_ready) begin
                    logic [WIDTH-1:0] e1;
                    e1 = q1.pop_front();
                    check("sb_out1_data", 32'(out1_data), 32'(e1));
                    $display("pop  ch1 data=%02h exp=%02h", out1_data, e1);
                end
                if (in_valid && m_ready) begin
                    if (in_sel) begin
                        q1.push_back(in_data);
                        m_cnt1 = m_cnt1 + 1'b1;
                    end else begin
                        q0.push_back(in_data);
                        m_cnt0 = m_cnt0 + 1'b1;
                    end
                    $display("push ch%0d data=%02h", in_sel, in_data);
                end
            end
        end
    end

    typedef struct {
        logic             valid;
        logic             sel;
        logic [WIDTH-1:0] data;
        logic             r0;
        logic             r1;
        logic             e_ready;
        logic             e_v0;
        logic [WIDTH-1:0] e_d0;
        logic             e_v1;
        logic [WIDTH-1:0] e_d1;
        logic [CNT_W-1:0] e_c0;
        logic [CNT_W-1:0] e_c1;
    } vec_t;

    vec_t vecs [12];

    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    initial begin
        // valid sel data r0 r1 | ready v0 d0 v1 d1 c0 c1  (expected values seen before the edge)
        vecs[0]  = '{1'b1, 1'b0, 5'h03, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 5'h00, 8'd0, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, 5'h1C, 1'b1, 1'b1, 1'b1, 1'b1, 5'h03, 1'b0, 5'h00, 8'd1, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 5'h11, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 1'b1, 5'h1C, 8'd1, 8'd1};
        vecs[3]  = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 1'b1, 5'h11, 1'b0, 5'h00, 8'd2, 8'd1};
        vecs[4]  = '{1'b1, 1'b0, 5'h0A, 1'b0, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 5'h00, 8'd2, 8'd1};
        vecs[5]  = '{1'b1, 1'b0, 5'h0B, 1'b0, 1'b1, 1'b1, 1'b1, 5'h0A, 1'b0, 5'h00, 8'd3, 8'd1};
        vecs[6]  = '{1'b1, 1'b0, 5'h0C, 1'b0, 1'b1, 1'b0, 1'b1, 5'h0A, 1'b0, 5'h00, 8'd4, 8'd1};
        vecs[7]  = '{1'b1, 1'b1, 5'h0C, 1'b0, 1'b0, 1'b1, 1'b1, 5'h0A, 1'b0, 5'h00, 8'd4, 8'd1};
        vecs[8]  = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b0, 1'b1, 5'h0A, 1'b1, 5'h0C, 8'd4, 8'd2};
        vecs[9]  = '{1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b1, 1'b1, 5'h0B, 1'b0, 5'h00, 8'd4, 8'd2};
        vecs[10] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 1'b1, 5'h0B, 1'b0, 5'h00, 8'd4, 8'd2};
        vecs[11] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 5'h00, 8'd4, 8'd2};

        // Reset and idle
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out0_valid", 32'(out0_valid), 32'd0);
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out0_data", 32'(out0_data), 32'd0);
        check("rst_out1_data", 32'(out1_data), 32'd0);
        check("rst_cnt0", 32'(cnt0), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);

        // Routing and backpressure vectors
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 drive(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].r0, vecs[i].r1);
            @(negedge clk);
            $display("vec %0d: ready=%0b v0=%0b d0=%02h v1=%0b d1=%02h c0=%0d c1=%0d",
                     i, in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1);
            check("vec_in_ready", 32'(in_ready), 32'(vecs[i].e_ready));
            check("vec_out0_valid", 32'(out0_valid), 32'(vecs[i].e_v0));
            check("vec_out1_valid", 32'(out1_valid), 32'(vecs[i].e_v1));
            if (vecs[i].e_v0) check("vec_out0_data", 32'(out0_data), 32'(vecs[i].e_d0));
            if (vecs[i].e_v1) check("vec_out1_data", 32'(out1_data), 32'(vecs[i].e_d1));
            check("vec_cnt0", 32'(cnt0), 32'(vecs[i].e_c0));
            check("vec_cnt1", 32'(cnt1), 32'(vecs[i].e_c1));
        end

        // Simultaneous push/pop on channel 1 with one word already held
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 5'h15, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 drive(1'b1, 1'b1, 5'(i + 1), 1'b1, 1'b1);
            @(negedge clk);
            check("pp_in_ready", 32'(in_ready), 32'd1);
            check("pp_out1_valid", 32'(out1_valid), 32'd1);
        end
        @(posedge clk);
        #1 drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        @(negedge clk);
        check("pp_one_left", 32'(out1_valid), 32'd1);
        @(negedge clk);
        check("pp_drained", 32'(out1_valid), 32'd0);

        // Counter wrap: 256 pushes to channel 0 bring cnt0 back to its start value
        begin
            logic [CNT_W-1:0] c0_start;
            logic [CNT_W-1:0] c1_start;
            c0_start = cnt0;
            c1_start = cnt1;
            for (int i = 0; i < 256; i++) begin
                @(posedge clk);
                #1 drive(1'b1, 1'b0, 5'(i), 1'b1, 1'b1);
                @(negedge clk);
                check("wrap_in_ready", 32'(in_ready), 32'd1);
            end
            @(posedge clk);
            #1 drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
            @(negedge clk);
            check("wrap_cnt0", 32'(cnt0), 32'(c0_start));
            check("wrap_cnt1", 32'(cnt1), 32'(c1_start));
        end

        // Mid-operation reset with both channels full
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 5'h1A, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 5'h1B, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 5'h0D, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 5'h0E, 1'b0, 1'b0);
        @(negedge clk);
        check("full_out0_valid", 32'(out0_valid), 32'd1);
        check("full_out1_valid", 32'(out1_valid), 32'd1);
        @(posedge clk);
        #1 begin
            drive(1'b1, 1'b0, 5'h1F, 1'b1, 1'b1);
            rst_n = 1'b0;
        end
        @(negedge clk);
        check("mid_full_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 begin
            rst_n = 1'b1;
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_out0_valid", 32'(out0_valid), 32'd0);
            check("mid_out1_valid", 32'(out1_valid), 32'd0);
            check("mid_cnt0", 32'(cnt0), 32'd0);
            check("mid_cnt1", 32'(cnt1), 32'd0);
            check("mid_in_ready", 32'(in_ready), 32'd1);
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
